// File: rtl/t_ff_pkg.sv
// Shared definitions for the T flip-flop bank.
//   mode_e : operating mode selected by the bank's 2-bit mode input.
package t_ff_pkg;

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_LOAD   = 2'b11
  } mode_e;

  localparam int unsigned MODE_W = 2;

endpackage : t_ff_pkg

// File: rtl/t_flipflop_cell.sv
// Single positive-edge T flip-flop with asynchronous active-low reset.
//   clk : clock
//   rst : asynchronous reset, active-low (clears q)
//   t   : toggle request, q inverts on the rising edge when high
//   q   : flip-flop output
module t_flipflop_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  logic state_q;
  logic state_d;

  // Toggle equation
  always_comb begin
    state_d = state_q ^ t;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= 1'b0;
    end else begin
      state_q <= state_d;
    end
  end

  assign q = state_q;

endmodule : t_flipflop_cell

// File: rtl/t_flipflop_bank.sv
// Bank of WIDTH T flip-flops with toggle / modulo up / down / load modes
// and a registered terminal-count pulse for cascading.
//   clk      : clock
//   rst      : asynchronous reset, active-low (q=0, tc=0)
//   en       : advance enable, 0 holds q
//   mode     : 00 toggle, 01 up, 10 down, 11 load
//   t        : per-bit toggle request (toggle mode)
//   load_val : parallel load value, saturated to MODULUS-1 (load mode)
//   q        : flip-flop outputs
//   tc       : terminal-count pulse, high in the cycle q shows the wrapped value
module t_flipflop_bank
  import t_ff_pkg::*;
#(
  parameter int unsigned       WIDTH   = 8,
  parameter longint unsigned   MODULUS = 64'(1) << WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  t,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  q,
  output logic              tc
);

  // Largest in-range count value; with MODULUS=2**WIDTH this is all ones
  // so the up-count wrap is the natural overflow.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] q_cells;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] tog;
  logic             tc_d;
  logic             tc_q;

  // Next-value selection and terminal-count detection
  always_comb begin
    nxt  = q_cells;
    tc_d = 1'b0;
    if (en) begin
      case (mode_e'(mode))
        MODE_TOGGLE: begin
          nxt = q_cells ^ t;
        end
        MODE_UP: begin
          // Out-of-range values are treated as terminal and wrap to zero
          if (q_cells >= MAX_VAL) begin
            nxt  = '0;
            tc_d = 1'b1;
          end else begin
            nxt = q_cells + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          if (q_cells == '0) begin
            nxt  = MAX_VAL;
            tc_d = 1'b1;
          end else if (q_cells > MAX_VAL) begin
            // Recover from an out-of-range value without a wrap pulse
            nxt = MAX_VAL;
          end else begin
            nxt = q_cells - WIDTH'(1);
          end
        end
        MODE_LOAD: begin
          nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end
        default: begin
          nxt = q_cells;
        end
      endcase
    end
  end

  // Cells only ever toggle: convert the next value into toggle requests
  always_comb begin
    tog = '0;
    if (en) begin
      tog = q_cells ^ nxt;
    end
  end

  // Flip-flop cells
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    t_flipflop_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (tog[i]),
      .q   (q_cells[i])
    );
  end

  // Terminal-count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= tc_d;
    end
  end

  assign q  = q_cells;
  assign tc = tc_q;

endmodule : t_flipflop_bank

// File: tb/tb_t_flipflop_bank.sv
// Directed scoreboard bench for t_flipflop_bank (WIDTH=4).
module tb_t_flipflop_bank;

  logic       clk = 1'b0;
  logic       rst;

  // Main bank, MODULUS=10
  logic       en;
  logic [1:0] mode;
  logic [3:0] t;
  logic [3:0] lv;
  logic [3:0] q;
  logic       tc;

  // MODULUS=16 bank
  logic       en16;
  logic [1:0] mode16;
  logic [3:0] lv16;
  logic [3:0] q16;
  logic       tc16;

  // Cascade pair, MODULUS=10
  logic       ca_en;
  logic [3:0] qa;
  logic       tca;
  logic [3:0] qb;
  logic       tcb;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;

  sb_t sb[$];

  always #5 clk = ~clk;

  t_flipflop_bank #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t),
    .load_val(lv), .q(q), .tc(tc)
  );

  t_flipflop_bank #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .rst(rst), .en(en16), .mode(mode16), .t(4'h0),
    .load_val(lv16), .q(q16), .tc(tc16)
  );

  t_flipflop_bank #(.WIDTH(4), .MODULUS(10)) u_a (
    .clk(clk), .rst(rst), .en(ca_en), .mode(2'b01), .t(4'h0),
    .load_val(4'h0), .q(qa), .tc(tca)
  );

  t_flipflop_bank #(.WIDTH(4), .MODULUS(10)) u_b (
    .clk(clk), .rst(rst), .en(tca), .mode(2'b01), .t(4'h0),
    .load_val(4'h0), .q(qb), .tc(tcb)
  );

  task automatic push(input string tag, input logic [7:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check_pop(input logic [7:0] obs);
    sb_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL sb_empty observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Drive the main bank for one edge and compare q and tc afterwards
  task automatic step(input string tag, input logic e_i, input logic [1:0] m_i,
                      input logic [3:0] t_i, input logic [3:0] lv_i,
                      input logic [3:0] exp_q, input logic exp_tc);
    en   = e_i;
    mode = m_i;
    t    = t_i;
    lv   = lv_i;
    push({tag, "_q"}, {4'h0, exp_q});
    push({tag, "_tc"}, {7'h0, exp_tc});
    @(posedge clk);
    #1;
    check_pop({4'h0, q});
    check_pop({7'h0, tc});
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b0;
    en     = 1'b0;
    mode   = 2'b00;
    t      = 4'h0;
    lv     = 4'h0;
    en16   = 1'b0;
    mode16 = 2'b00;
    lv16   = 4'h0;
    ca_en  = 1'b0;

    // Reset state before any edge
    #3;
    push("rst_q", 8'h00);
    push("rst_tc", 8'h00);
    push("rst_q16", 8'h00);
    push("rst_casc", 8'h00);
    check_pop({4'h0, q});
    check_pop({7'h0, tc});
    check_pop({4'h0, q16});
    check_pop({qb, qa});
    @(posedge clk);
    #1;
    rst = 1'b1;

    // UP wrap from 0: 1..9,0,1,2 with tc only on the wrap
    for (int i = 1; i <= 12; i++) begin
      step("up", 1'b1, 2'b01, 4'h0, 4'h0, 4'(i % 10), (i == 10));
    end

    // DOWN wrap then en gating
    step("dn1", 1'b1, 2'b10, 4'h0, 4'h0, 4'd1, 1'b0);
    step("dn0", 1'b1, 2'b10, 4'h0, 4'h0, 4'd0, 1'b0);
    step("dn9", 1'b1, 2'b10, 4'h0, 4'h0, 4'd9, 1'b1);
    step("hold1", 1'b0, 2'b10, 4'h0, 4'h0, 4'd9, 1'b0);
    step("hold2", 1'b0, 2'b01, 4'hF, 4'h0, 4'd9, 1'b0);

    // TOGGLE and out-of-range recovery
    step("ld0", 1'b1, 2'b11, 4'h0, 4'h0, 4'd0, 1'b0);
    step("tg1", 1'b1, 2'b00, 4'b1010, 4'h0, 4'b1010, 1'b0);
    step("tg2", 1'b1, 2'b00, 4'b1010, 4'h0, 4'b0000, 1'b0);
    step("tg3", 1'b1, 2'b00, 4'b1010, 4'h0, 4'b1010, 1'b0);
    step("oor_up", 1'b1, 2'b01, 4'h0, 4'h0, 4'd0, 1'b1);
    step("tg4", 1'b1, 2'b00, 4'b1100, 4'h0, 4'b1100, 1'b0);
    step("oor_dn", 1'b1, 2'b10, 4'h0, 4'h0, 4'd9, 1'b0);

    // LOAD saturation
    step("ld6", 1'b1, 2'b11, 4'h0, 4'd6, 4'd6, 1'b0);
    step("ld15", 1'b1, 2'b11, 4'h0, 4'd15, 4'd9, 1'b0);
    step("ld7", 1'b1, 2'b11, 4'h0, 4'd7, 4'd7, 1'b0);

    // Asynchronous reset mid-cycle, then held across edges with en=1
    rst = 1'b0;
    #2;
    push("arst_q", 8'h00);
    push("arst_tc", 8'h00);
    check_pop({4'h0, q});
    check_pop({7'h0, tc});
    for (int i = 0; i < 3; i++) begin
      step("rst_hold", 1'b1, 2'b01, 4'h0, 4'h0, 4'd0, 1'b0);
    end
    rst = 1'b1;
    step("rel", 1'b1, 2'b01, 4'h0, 4'h0, 4'd1, 1'b0);
    en = 1'b0;

    // MODULUS=16: full-range load then natural overflow
    en16   = 1'b1;
    mode16 = 2'b11;
    lv16   = 4'd15;
    push("m16_ld_q", 8'h0F);
    push("m16_ld_tc", 8'h00);
    @(posedge clk);
    #1;
    check_pop({4'h0, q16});
    check_pop({7'h0, tc16});
    mode16 = 2'b01;
    push("m16_up_q", 8'h00);
    push("m16_up_tc", 8'h01);
    @(posedge clk);
    #1;
    check_pop({4'h0, q16});
    check_pop({7'h0, tc16});
    en16 = 1'b0;

    // Cascade: B advances on the edge after A wraps
    ca_en = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      push("casc_val", {4'((i - 1) / 10), 4'(i % 10)});
      push("casc_tca", {7'h0, (i % 10 == 0)});
      @(posedge clk);
      #1;
      check_pop({qb, qa});
      check_pop({7'h0, tca});
    end
    ca_en = 1'b0;
    push("casc_final", 8'h25);
    check_pop({qb, qa});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_t_flipflop_bank

// File: doc/t_flipflop_bank.md
# t_flipflop_bank

Parametrised bank of WIDTH T flip-flops sharing one clock and an asynchronous active-low reset. It is the multi-bit successor of the single positive-edge T flip-flop. A mode input selects the bank's behaviour: independent per-bit toggle, synchronous modulo-MODULUS up count, down count, or parallel load. The bank is the general-purpose toggle/count primitive for the behavioral project, and a registered terminal-count pulse allows banks to be cascaded.

## Interface
- WIDTH, 8, number of flip-flops (1..32).
- MODULUS, 2**WIDTH, count modulus in count modes (2..2**WIDTH).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low; 0 forces the reset state immediately.
- en  in  1  advance enable; 0 holds q.
- mode  in  2  00 TOGGLE, 01 UP, 10 DOWN, 11 LOAD.
- t  in  WIDTH  per-bit toggle request; used only in TOGGLE.
- load_val  in  WIDTH  parallel load value; used only in LOAD.
- q  out  WIDTH  flip-flop outputs.
- tc  out  1  registered terminal-count pulse.

## Operation
- Reset (rst=0, asynchronous): q=0 and tc=0. Both hold while rst=0, regardless of clk or other inputs. Release is synchronous to the next rising edge. The first update can occur on the first rising edge with rst=1.
- en=0: q holds and tc<=0. There is no other side effect.
- With en=1, the next value (nxt) is set by mode:
  - TOGGLE: nxt = q ^ t. Bits with t[i]=1 invert; other bits hold. tc<=0.
  - UP:
    - If q >= MODULUS-1: nxt=0 and tc<=1.
    - Otherwise: nxt=q+1 and tc<=0.
  - DOWN:
    - If q==0: nxt=MODULUS-1 and tc<=1.
    - If q > MODULUS-1 (reachable only via TOGGLE): nxt=MODULUS-1 and tc<=0.
    - Otherwise: nxt=q-1 and tc<=0.
  - LOAD: nxt = min(load_val, MODULUS-1), saturating. tc<=0.
- Every bit is a true T flip-flop. Its toggle input is tog[i] = q[i] ^ nxt[i], and tog=0 when en=0. No D-style bypass of the cells.
- Out-of-range q (only reachable via TOGGLE when MODULUS < 2**WIDTH):
  - UP treats it as terminal and wraps to 0 with tc=1.
  - DOWN steps to MODULUS-1 as defined above.
- A mode change takes effect on the next edge. Any mode sequence is legal, and switching mode loses no state.
- Arithmetic is unsigned, WIDTH bits. The comparison against MODULUS-1 uses a WIDTH-bit constant. MODULUS=2**WIDTH makes wrap the natural overflow.

## Timing
- Latency is one cycle: inputs sampled at edge k appear on q after edge k.
- tc is registered and coincides with the wrapped value of q. It is high for exactly one cycle per wrap.
- Cascading: connect tc of bank A to en of bank B, with B in UP mode. B then advances on the edge after A wraps.
- Continuous UP with en=1 pulses tc once every MODULUS cycles.
- Asserting rst mid-count clears q and tc within the same cycle (asynchronous). A pending tc is discarded.
- rst de-asserted in the same cycle as en=1: the edge that samples rst=1 performs the first update.

## Structure
- Shared package t_ff_pkg holds the mode constants MODE_TOGGLE=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_LOAD=2'b11.
- Sub-module t_flipflop_cell is the single-bit cell: ports clk, rst (async active-low), t, q. Behaviour: q<=0 on reset, else q<=q^t. The top instantiates WIDTH cells with a generate loop.
- Top holds: next-value/compare logic, the toggle-vector derivation, and the tc register.
- No other state exists.

## Test plan
The bench uses WIDTH=4, MODULUS=10 unless stated.
- Reset: drive rst=0 mid-cycle with q=7 -> q=0 and tc=0 before the next edge. Hold rst=0 for 3 edges with en=1 -> q stays 0.
- UP wrap: start from q=0, UP, en=1 for 12 edges -> q runs 1..9,0,1,2. tc=1 only in the cycle q becomes 0.
- DOWN wrap plus en gating:
  - From q=2, DOWN -> q=1,0,9. tc=1 only with the q=9 value.
  - Then en=0 for 2 edges -> q holds 9 and tc=0.
- TOGGLE: q=4'b0000, t=4'b1010 for 2 edges -> q=1010 then 0000.
  - Then q=4'b1010 (10) in UP -> q=0 and tc=1.
  - Repeat from q=4'b1100 (12) in DOWN -> q=9 and tc=0.
- LOAD saturation: load_val=6 -> q=6. load_val=15 -> q=9.
  - MODULUS=16 variant: load_val=15 -> q=15, then UP -> q=0 and tc=1.
- Cascade: two banks (MODULUS=10), A.tc drives B.en, both UP, 25 edges -> {B,A} reads decimal 25 as B=2, A=5. B advances exactly when A wraps.
